// File: rtl/fft_pkg.sv
// fft_pkg: numeric format shared by the R2MDC FFT pipeline (Q7.8 components, complex samples)
// Provides DATA_W/FRAC_BITS/INT_BITS, the complex sample width and a packed complex type.
package fft_pkg;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int INT_BITS  = 7;
    localparam int CPLX_W    = 2 * DATA_W;
    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;
    function automatic cplx_t to_cplx(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
        return '{re: re, im: im};
    endfunction
endpackage

// File: rtl/r2mdc_delay_line.sv
// r2mdc_delay_line: enabled shift register, DEPTH stages of WIDTH bits, synchronously cleared
// Ports: clk, rst (sync, active-high clear), en (shift enable), din, dout (din from DEPTH enables ago).
module r2mdc_delay_line
    import fft_pkg::*;
#(
    parameter int WIDTH = CPLX_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end
    assign dout = mem[DEPTH-1];
endmodule

// File: rtl/r2mdc_commutator.sv
// r2mdc_commutator: R2MDC delay-commutator presenting (x[j], x[j+D]) pairs to the next butterfly
// Ports: clk, rst (sync, active-high); in_valid with lanes in0 (upper, Y0) and in1 (lower, Y1);
//        registered out_valid with out0 (butterfly A) and out1 (butterfly B). Data is passed bit-exact.
module r2mdc_commutator
    import fft_pkg::*;
#(
    parameter int DELAY  = 4,
    parameter int DATA_W = fft_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in0_re,
    input  logic [DATA_W-1:0] in0_im,
    input  logic [DATA_W-1:0] in1_re,
    input  logic [DATA_W-1:0] in1_im,
    output logic              out_valid,
    output logic [DATA_W-1:0] out0_re,
    output logic [DATA_W-1:0] out0_im,
    output logic [DATA_W-1:0] out1_re,
    output logic [DATA_W-1:0] out1_im
);
    localparam int LD = $clog2(DELAY);
    localparam int FW = $clog2(DELAY + 1);
    localparam int CW = 2 * DATA_W;
    logic [LD:0]   cnt;
    logic [FW-1:0] fill;
    logic          primed, sw;
    logic [CW-1:0] in0, in1, d1, top, bot, dtop;
    assign in0    = {in0_re, in0_im};
    assign in1    = {in1_re, in1_im};
    assign sw     = cnt[LD];
    assign primed = fill == FW'(DELAY);
    // 2x2 switch: lane 0 goes straight up in the first half of each 2D window, down in the second
    assign top    = sw ? d1 : in0;
    assign bot    = sw ? in0 : d1;
    r2mdc_delay_line #(.WIDTH(CW), .DEPTH(DELAY)) u_dl_lower (
        .clk(clk), .rst(rst), .en(in_valid), .din(in1), .dout(d1)
    );
    r2mdc_delay_line #(.WIDTH(CW), .DEPTH(DELAY)) u_dl_upper (
        .clk(clk), .rst(rst), .en(in_valid), .din(top), .dout(dtop)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            {out0_re, out0_im, out1_re, out1_im} <= '0;
        end else begin
            // a gap cycle drops out_valid but leaves the data registers holding
            out_valid <= in_valid & primed;
            if (in_valid) begin
                cnt  <= cnt + 1'b1;
                fill <= primed ? fill : fill + 1'b1;
                {out0_re, out0_im} <= dtop;
                {out1_re, out1_im} <= bot;
            end
        end
    end
endmodule
